reservation_station: RTL and testbench

- Consumer end of the common data bus: a small out-of-order issue queue between the dispatch stage and the ALU.
- Holds dispatched instructions whose source operands may still be pending on producer tags.
- Snoops every CDB broadcast (tag, data) and captures results into waiting operands.
- Issues the lowest-index entry whose operands are both ready to the ALU via valid/ready.

---
 rtl/reservation_station_if.sv | 56 +++++
 rtl/reservation_station.sv | 128 ++++++++++++
 tb/tb_reservation_station.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the reservation station.
// The master drives dispatch, CDB, flush and issue_ready. The slave is the station.
interface reservation_station_if #(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8
) ();
  logic                      flush;

  logic                      dispatch_valid;
  logic                      dispatch_ready;
  logic [CTRL_WIDTH-1:0]     dispatch_ctrl;
  logic [TAG_WIDTH-1:0]      dispatch_dst_tag;
  logic                      dispatch_src_a_ready;
  logic [TAG_WIDTH-1:0]      dispatch_src_a_tag;
  logic [DATA_WIDTH-1:0]     dispatch_src_a_data;
  logic                      dispatch_src_b_ready;
  logic [TAG_WIDTH-1:0]      dispatch_src_b_tag;
  logic [DATA_WIDTH-1:0]     dispatch_src_b_data;

  logic                      cdb_valid;
  logic [TAG_WIDTH-1:0]      cdb_tag;
  logic [DATA_WIDTH-1:0]     cdb_data;

  logic                      issue_valid;
  logic                      issue_ready;
  logic [CTRL_WIDTH-1:0]     issue_ctrl;
  logic [TAG_WIDTH-1:0]      issue_dst_tag;
  logic [DATA_WIDTH-1:0]     issue_src_a;
  logic [DATA_WIDTH-1:0]     issue_src_b;

  logic [$clog2(DEPTH):0]    occupancy;

  modport master (
    output flush,
    output dispatch_valid, dispatch_ctrl, dispatch_dst_tag,
    output dispatch_src_a_ready, dispatch_src_a_tag, dispatch_src_a_data,
    output dispatch_src_b_ready, dispatch_src_b_tag, dispatch_src_b_data,
    output cdb_valid, cdb_tag, cdb_data,
    output issue_ready,
    input  dispatch_ready, issue_valid, issue_ctrl, issue_dst_tag,
    input  issue_src_a, issue_src_b, occupancy
  );

  modport slave (
    input  flush,
    input  dispatch_valid, dispatch_ctrl, dispatch_dst_tag,
    input  dispatch_src_a_ready, dispatch_src_a_tag, dispatch_src_a_data,
    input  dispatch_src_b_ready, dispatch_src_b_tag, dispatch_src_b_data,
    input  cdb_valid, cdb_tag, cdb_data,
    input  issue_ready,
    output dispatch_ready, issue_valid, issue_ctrl, issue_dst_tag,
    output issue_src_a, issue_src_b, occupancy
  );
endinterface

// File: rtl/reservation_station.sv
// Out-of-order issue queue that snoops the CDB and wakes pending operands.
// It issues the lowest-index entry whose two operands are ready.
module reservation_station #(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  reservation_station_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [DEPTH-1:0]      valid;
  logic [DEPTH-1:0]      a_rdy;
  logic [DEPTH-1:0]      b_rdy;
  logic [CTRL_WIDTH-1:0] ctrl   [DEPTH];
  logic [TAG_WIDTH-1:0]  dst    [DEPTH];
  logic [TAG_WIDTH-1:0]  a_tag  [DEPTH];
  logic [TAG_WIDTH-1:0]  b_tag  [DEPTH];
  logic [DATA_WIDTH-1:0] a_data [DEPTH];
  logic [DATA_WIDTH-1:0] b_data [DEPTH];

  logic [DEPTH-1:0]      wake_a;
  logic [DEPTH-1:0]      wake_b;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic                  cand_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [OCC_W-1:0]      occ;
  logic                  do_disp;
  logic                  do_issue;
  logic                  disp_a_rdy;
  logic                  disp_b_rdy;
  logic [DATA_WIDTH-1:0] disp_a_data;
  logic [DATA_WIDTH-1:0] disp_b_data;

  // Free slot, issue candidate and occupancy all come from registered state only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    cand_found = 1'b0;
    sel_idx    = '0;
    occ        = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid[i] && a_rdy[i] && b_rdy[i]) begin
        cand_found = 1'b1;
        sel_idx    = IDX_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(valid[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake_a[i] = valid[i] && !a_rdy[i] && bus.cdb_valid && (a_tag[i] == bus.cdb_tag);
      wake_b[i] = valid[i] && !b_rdy[i] && bus.cdb_valid && (b_tag[i] == bus.cdb_tag);
    end
  end

  // A broadcast arriving together with the dispatch is captured directly.
  assign disp_a_rdy  = bus.dispatch_src_a_ready ||
                       (bus.cdb_valid && (bus.cdb_tag == bus.dispatch_src_a_tag));
  assign disp_b_rdy  = bus.dispatch_src_b_ready ||
                       (bus.cdb_valid && (bus.cdb_tag == bus.dispatch_src_b_tag));
  assign disp_a_data = bus.dispatch_src_a_ready ? bus.dispatch_src_a_data : bus.cdb_data;
  assign disp_b_data = bus.dispatch_src_b_ready ? bus.dispatch_src_b_data : bus.cdb_data;

  assign do_disp  = bus.dispatch_valid && free_found && !bus.flush;
  assign do_issue = bus.issue_valid && bus.issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      a_rdy <= '0;
      b_rdy <= '0;
    end else if (bus.flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_issue && (sel_idx == IDX_W'(i))) begin
          valid[i] <= 1'b0;
        end
        if (do_disp && (free_idx == IDX_W'(i))) begin
          valid[i] <= 1'b1;
          a_rdy[i] <= disp_a_rdy;
          b_rdy[i] <= disp_b_rdy;
        end else begin
          if (wake_a[i]) a_rdy[i] <= 1'b1;
          if (wake_b[i]) b_rdy[i] <= 1'b1;
        end
      end
    end
  end

  // Payload carries no reset; it is only observed through valid entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_disp && (free_idx == IDX_W'(i))) begin
        ctrl[i]   <= bus.dispatch_ctrl;
        dst[i]    <= bus.dispatch_dst_tag;
        a_tag[i]  <= bus.dispatch_src_a_tag;
        b_tag[i]  <= bus.dispatch_src_b_tag;
        a_data[i] <= disp_a_data;
        b_data[i] <= disp_b_data;
      end else begin
        if (wake_a[i]) a_data[i] <= bus.cdb_data;
        if (wake_b[i]) b_data[i] <= bus.cdb_data;
      end
    end
  end

  assign bus.dispatch_ready = free_found;
  assign bus.occupancy      = occ;
  assign bus.issue_valid    = cand_found && !bus.flush;
  assign bus.issue_ctrl     = cand_found ? ctrl[sel_idx]   : '0;
  assign bus.issue_dst_tag  = cand_found ? dst[sel_idx]    : '0;
  assign bus.issue_src_a    = cand_found ? a_data[sel_idx] : '0;
  assign bus.issue_src_b    = cand_found ? b_data[sel_idx] : '0;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue, wakeup, bypass, ordering, stall, flush, reset.
module tb_reservation_station;
  localparam int DEPTH = 4;
  localparam int TW    = 6;
  localparam int DW    = 32;
  localparam int CW    = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  reservation_station_if #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  reservation_station #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush                = 1'b0;
    bus.dispatch_valid       = 1'b0;
    bus.dispatch_ctrl        = '0;
    bus.dispatch_dst_tag     = '0;
    bus.dispatch_src_a_ready = 1'b0;
    bus.dispatch_src_a_tag   = '0;
    bus.dispatch_src_a_data  = '0;
    bus.dispatch_src_b_ready = 1'b0;
    bus.dispatch_src_b_tag   = '0;
    bus.dispatch_src_b_data  = '0;
    bus.cdb_valid            = 1'b0;
    bus.cdb_tag              = '0;
    bus.cdb_data             = '0;
    bus.issue_ready          = 1'b0;
  endtask

  task automatic set_dispatch(input logic [CW-1:0] c, input logic [TW-1:0] d,
                              input logic ar, input logic [TW-1:0] at, input logic [DW-1:0] ad,
                              input logic br, input logic [TW-1:0] bt, input logic [DW-1:0] bd);
    bus.dispatch_valid       = 1'b1;
    bus.dispatch_ctrl        = c;
    bus.dispatch_dst_tag     = d;
    bus.dispatch_src_a_ready = ar;
    bus.dispatch_src_a_tag   = at;
    bus.dispatch_src_a_data  = ad;
    bus.dispatch_src_b_ready = br;
    bus.dispatch_src_b_tag   = bt;
    bus.dispatch_src_b_data  = bd;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.occupancy !== 3'd0 || bus.issue_valid !== 1'b0 || bus.dispatch_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl occ=%0d iv=%b dr=%b required occ=0 iv=0 dr=1",
               bus.occupancy, bus.issue_valid, bus.dispatch_ready);
    end
    checks++;
    if (bus.issue_ctrl !== 8'h0 || bus.issue_dst_tag !== 6'd0 ||
        bus.issue_src_a !== 32'h0 || bus.issue_src_b !== 32'h0) begin
      failures++;
      $display("FAIL reset_payload ctrl=%h dst=%0d a=%h b=%h required all 0",
               bus.issue_ctrl, bus.issue_dst_tag, bus.issue_src_a, bus.issue_src_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_issue();
    set_dispatch(8'h21, 6'd3, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
    bus.issue_ready = 1'b1;
    step();
    bus.dispatch_valid = 1'b0;
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_src_a !== 32'd5 || bus.issue_src_b !== 32'd7 ||
        bus.issue_dst_tag !== 6'd3 || bus.issue_ctrl !== 8'h21) begin
      failures++;
      $display("FAIL basic_issue iv=%b a=%0d b=%0d dst=%0d ctrl=%h required 1 5 7 3 21",
               bus.issue_valid, bus.issue_src_a, bus.issue_src_b, bus.issue_dst_tag, bus.issue_ctrl);
    end
    checks++;
    if (bus.occupancy !== 3'd1) begin
      failures++;
      $display("FAIL basic_occ1 occ=%0d required 1", bus.occupancy);
    end
    step();
    checks++;
    if (bus.occupancy !== 3'd0 || bus.issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_freed occ=%0d iv=%b required 0 0", bus.occupancy, bus.issue_valid);
    end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_wakeup();
    set_dispatch(8'h05, 6'd5, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'd2);
    step();
    bus.dispatch_valid = 1'b0;
    checks++;
    if (bus.issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL wake_wait1 iv=%b required 0", bus.issue_valid);
    end
    step();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd9;
    bus.cdb_data  = 32'hDEAD;
    #1;
    checks++;
    if (bus.issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL wake_cdb_cycle iv=%b required 0", bus.issue_valid);
    end
    step();
    bus.cdb_valid = 1'b0;
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_src_a !== 32'hDEAD || bus.issue_src_b !== 32'd2 ||
        bus.issue_dst_tag !== 6'd5) begin
      failures++;
      $display("FAIL wake_issue iv=%b a=%h b=%0d dst=%0d required 1 dead 2 5",
               bus.issue_valid, bus.issue_src_a, bus.issue_src_b, bus.issue_dst_tag);
    end
    bus.issue_ready = 1'b1;
    step();
    bus.issue_ready = 1'b0;
    checks++;
    if (bus.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL wake_freed occ=%0d required 0", bus.occupancy);
    end
  endtask

  task automatic test_bypass();
    set_dispatch(8'h07, 6'd6, 1'b0, 6'd4, 32'h99, 1'b1, 6'd0, 32'h22);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd4;
    bus.cdb_data  = 32'h11;
    step();
    bus.dispatch_valid = 1'b0;
    bus.cdb_valid      = 1'b0;
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_src_a !== 32'h11 || bus.issue_src_b !== 32'h22) begin
      failures++;
      $display("FAIL bypass iv=%b a=%h b=%h required 1 11 22",
               bus.issue_valid, bus.issue_src_a, bus.issue_src_b);
    end
    bus.issue_ready = 1'b1;
    step();
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_fill_order();
    for (int k = 0; k < DEPTH; k++) begin
      set_dispatch(8'(k), 6'(10 + k), 1'b0, 6'd1, 32'h0, 1'b1, 6'd0, 32'(k));
      step();
    end
    checks++;
    if (bus.dispatch_ready !== 1'b0 || bus.occupancy !== 3'd4 || bus.issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL full dr=%b occ=%0d iv=%b required 0 4 0",
               bus.dispatch_ready, bus.occupancy, bus.issue_valid);
    end
    step();
    bus.dispatch_valid = 1'b0;
    checks++;
    if (bus.occupancy !== 3'd4) begin
      failures++;
      $display("FAIL full_hold occ=%0d required 4", bus.occupancy);
    end
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd1;
    bus.cdb_data  = 32'h100;
    step();
    bus.cdb_valid   = 1'b0;
    bus.issue_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (bus.issue_valid !== 1'b1 || bus.issue_dst_tag !== 6'(10 + k) ||
          bus.issue_src_a !== 32'h100 || bus.issue_src_b !== 32'(k)) begin
        failures++;
        $display("FAIL order_%0d iv=%b dst=%0d a=%h b=%0d required 1 %0d 100 %0d",
                 k, bus.issue_valid, bus.issue_dst_tag, bus.issue_src_a, bus.issue_src_b, 10 + k, k);
      end
      step();
      if (k == 0) begin
        checks++;
        if (bus.dispatch_ready !== 1'b1 || bus.occupancy !== 3'd3) begin
          failures++;
          $display("FAIL ready_after_issue dr=%b occ=%0d required 1 3",
                   bus.dispatch_ready, bus.occupancy);
        end
      end
    end
    bus.issue_ready = 1'b0;
    checks++;
    if (bus.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL order_drained occ=%0d required 0", bus.occupancy);
    end
  endtask

  task automatic test_stall();
    set_dispatch(8'h30, 6'd20, 1'b1, 6'd0, 32'hA0, 1'b1, 6'd0, 32'hB0);
    step();
    set_dispatch(8'h31, 6'd21, 1'b1, 6'd0, 32'hA1, 1'b1, 6'd0, 32'hB1);
    step();
    bus.dispatch_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.issue_valid !== 1'b1 || bus.issue_dst_tag !== 6'd20 || bus.issue_src_a !== 32'hA0 ||
          bus.issue_ctrl !== 8'h30) begin
        failures++;
        $display("FAIL stall_hold_%0d iv=%b dst=%0d a=%h ctrl=%h required 1 20 a0 30",
                 k, bus.issue_valid, bus.issue_dst_tag, bus.issue_src_a, bus.issue_ctrl);
      end
      step();
    end
    bus.issue_ready = 1'b1;
    step();
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_dst_tag !== 6'd21 || bus.issue_src_b !== 32'hB1) begin
      failures++;
      $display("FAIL stall_second iv=%b dst=%0d b=%h required 1 21 b1",
               bus.issue_valid, bus.issue_dst_tag, bus.issue_src_b);
    end
    step();
    bus.issue_ready = 1'b0;
    checks++;
    if (bus.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL stall_drained occ=%0d required 0", bus.occupancy);
    end
  endtask

  task automatic test_back_to_back();
    set_dispatch(8'h40, 6'd30, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
    step();
    set_dispatch(8'h41, 6'd31, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 32'h4);
    bus.issue_ready = 1'b1;
    step();
    bus.dispatch_valid = 1'b0;
    checks++;
    if (bus.occupancy !== 3'd1 || bus.issue_dst_tag !== 6'd31 || bus.issue_src_a !== 32'h3) begin
      failures++;
      $display("FAIL b2b occ=%0d dst=%0d a=%h required 1 31 3",
               bus.occupancy, bus.issue_dst_tag, bus.issue_src_a);
    end
    step();
    bus.issue_ready = 1'b0;
    checks++;
    if (bus.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL b2b_drained occ=%0d required 0", bus.occupancy);
    end
  endtask

  task automatic test_flush_and_reset();
    for (int k = 0; k < 3; k++) begin
      set_dispatch(8'h50, 6'(40 + k), 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 32'h6);
      step();
    end
    set_dispatch(8'h51, 6'd50, 1'b1, 6'd0, 32'h7, 1'b1, 6'd0, 32'h8);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.issue_valid !== 1'b0 || bus.occupancy !== 3'd3) begin
      failures++;
      $display("FAIL flush_cycle iv=%b occ=%0d required 0 3", bus.issue_valid, bus.occupancy);
    end
    step();
    bus.flush          = 1'b0;
    bus.dispatch_valid = 1'b0;
    checks++;
    if (bus.occupancy !== 3'd0 || bus.issue_valid !== 1'b0 || bus.dispatch_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_after occ=%0d iv=%b dr=%b required 0 0 1",
               bus.occupancy, bus.issue_valid, bus.dispatch_ready);
    end
    set_dispatch(8'h60, 6'd60, 1'b1, 6'd0, 32'h9, 1'b1, 6'd0, 32'hA);
    step();
    step();
    bus.dispatch_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.occupancy !== 3'd0 || bus.issue_valid !== 1'b0 || bus.dispatch_ready !== 1'b1 ||
        bus.issue_dst_tag !== 6'd0 || bus.issue_src_a !== 32'h0) begin
      failures++;
      $display("FAIL async_reset occ=%0d iv=%b dr=%b dst=%0d a=%h required 0 0 1 0 0",
               bus.occupancy, bus.issue_valid, bus.dispatch_ready, bus.issue_dst_tag, bus.issue_src_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_bypass();
    test_fill_order();
    test_stall();
    test_back_to_back();
    test_flush_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
